// File: rtl/calc_queue.sv
// ---------------------------------------------------------------------------
// calc_queue
//   Operand queue for the queue calculator. A circular FIFO of WIDTH-bit
//   entries whose two oldest entries are presented to the ALU as `operands`.
//   Each strobed instruction from the ALU either commits a queue operation
//   (push, sleep, pop, get-and-push) or drops the block into a sticky ERR
//   state that records the cause. The ERR state is left only through err_clr.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : asynchronous reset, active low
//   op_valid  : one-cycle strobe qualifying queue_op / result / calc_err
//   queue_op  : queue operation requested by the ALU
//   result    : value to enqueue for push and get-and-push
//   calc_err  : ALU calculation error for this instruction
//   err_clr   : returns the block from ERR to RUN (ignored in RUN)
//   operands  : [WIDTH-1:0] = head entry, [2*WIDTH-1:WIDTH] = head+1 entry
//   count     : number of valid entries
//   empty     : count == 0
//   full      : count == DEPTH
//   err       : high while in ERR
//   err_code  : 00 none, 01 overflow, 10 underflow, 11 calc error
//   op_done   : one-cycle pulse the cycle after an error-free commit
// ---------------------------------------------------------------------------
module calc_queue #(
    parameter int         DEPTH          = 8,
    parameter int         WIDTH          = 8,
    parameter logic [1:0] Q_PUSH         = 2'b00,
    parameter logic [1:0] Q_SLEEP        = 2'b01,
    parameter logic [1:0] Q_POP          = 2'b11,
    parameter logic [1:0] Q_GET_AND_PUSH = 2'b10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    input  logic [1:0]                 queue_op,
    input  logic [WIDTH-1:0]           result,
    input  logic                       calc_err,
    input  logic                       err_clr,
    output logic [2*WIDTH-1:0]         operands,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic                       op_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_OVER  = 2'b01;
    localparam logic [1:0] CODE_UNDER = 2'b10;
    localparam logic [1:0] CODE_CALC  = 2'b11;

    typedef enum logic {S_RUN, S_ERR} state_t;

    state_t             state_reg,    state_next;
    logic [PTR_W-1:0]   head_reg,     head_next;
    logic [PTR_W-1:0]   tail_reg,     tail_next;
    logic [CNT_W-1:0]   count_reg,    count_next;
    logic [1:0]         err_code_reg, err_code_next;
    logic               op_done_reg,  op_done_next;
    logic               wr_en;

    logic [WIDTH-1:0]   mem [DEPTH];

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_RUN;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            err_code_reg <= CODE_NONE;
            op_done_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            err_code_reg <= err_code_next;
            op_done_reg  <= op_done_next;
        end
    end

    // Queue storage is not reset; only the pointers define what is valid.
    // The write is blocked while rst is asserted so a strobe arriving during
    // reset cannot disturb the array.
    always_ff @(posedge clk) begin
        if (wr_en && rst) begin
            mem[tail_reg] <= result;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        head_next     = head_reg;
        tail_next     = tail_reg;
        count_next    = count_reg;
        err_code_next = err_code_reg;
        op_done_next  = 1'b0;
        wr_en         = 1'b0;

        case (state_reg)
            S_RUN: begin
                if (op_valid) begin
                    if (calc_err) begin
                        state_next    = S_ERR;
                        err_code_next = CODE_CALC;
                    end else if (queue_op == Q_PUSH && count_reg == DEPTH_CNT) begin
                        state_next    = S_ERR;
                        err_code_next = CODE_OVER;
                    end else if ((queue_op == Q_POP && count_reg == '0) ||
                                 (queue_op == Q_GET_AND_PUSH && count_reg < CNT_W'(2))) begin
                        state_next    = S_ERR;
                        err_code_next = CODE_UNDER;
                    end else begin
                        op_done_next = 1'b1;
                        case (queue_op)
                            Q_PUSH: begin
                                wr_en      = 1'b1;
                                tail_next  = tail_reg + PTR_W'(1);
                                count_next = count_reg + CNT_W'(1);
                            end
                            Q_POP: begin
                                head_next  = head_reg + PTR_W'(1);
                                count_next = count_reg - CNT_W'(1);
                            end
                            Q_GET_AND_PUSH: begin
                                // When full, tail == head, so the write reuses
                                // the head slot that is being consumed.
                                wr_en      = 1'b1;
                                head_next  = head_reg + PTR_W'(2);
                                tail_next  = tail_reg + PTR_W'(1);
                                count_next = count_reg - CNT_W'(1);
                            end
                            Q_SLEEP: begin
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    state_next    = S_RUN;
                    err_code_next = CODE_NONE;
                end
            end
            default: begin
                state_next = S_RUN;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode (registered state only, no path from any input)
    // -----------------------------------------------------------------------
    always_comb begin
        count    = count_reg;
        empty    = (count_reg == '0);
        full     = (count_reg == DEPTH_CNT);
        err      = (state_reg == S_ERR);
        err_code = err_code_reg;
        op_done  = op_done_reg;
    end

    // Operand lane gi shows entry head+gi, or zero when that entry is not valid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [PTR_W-1:0] rd_idx;
            assign rd_idx = head_reg + PTR_W'(gi);
            assign operands[gi*WIDTH +: WIDTH] =
                (count_reg > CNT_W'(gi)) ? mem[rd_idx] : '0;
        end
    endgenerate

endmodule
